rom_region_loader: RTL and testbench

- Sequencer for the ROM download stream on the clk_bram domain.
- Parses a region header at the start of the ioctl stream, then routes each payload byte to one region:
  - block-RAM regions: sample offset table, protection data, future tables; driven through bram_wr/bram_addr/bram_data/bram_cs;
  - SDRAM regions: sample ROM, CPU ROMs; driven through a req/ack handshake with ioctl back-pressure.
- Replaces hard-coded per-region address decoding in the top level.

---
 rtl/rom_region_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_rom_region_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_region_loader.sv
// rom_region_loader
//   Sequencer for the ROM download stream (clk_bram domain). The start of the
//   ioctl stream is a table of NUM_REGIONS header entries. Each entry holds a
//   type byte and a 24-bit big-endian length. The payload that follows is routed
//   region by region:
//     type 1 = block RAM : one-cycle bram_wr strobe, bram_cs = 1 << region index,
//                          bram_addr restarts at 0 for each region
//     type 2 = SDRAM     : level sdram_req held until sdram_ack, ioctl_wait
//                          stalls the source meanwhile, SDRAM regions pack
//                          contiguously from address 0
//     type 3 = skip      : bytes are discarded
//     other  = unused    : entry is passed over
//
//   Optional feature macro: REGION_CHECKSUM_EN
//     When it is defined, each header entry grows a fifth byte. That byte is the
//     expected 8-bit modular sum of the region payload, and a mismatch at region
//     end sets load_err. When it is undefined, entries are 4 bytes and no sum
//     logic is built.
//
// Ports
//   clk_bram        clock
//   reset           asynchronous, active-high reset
//   ioctl_download  high while a download is in progress
//   ioctl_wr        one-cycle byte strobe
//   ioctl_dout      download byte
//   ioctl_wait      stall request to the ioctl source
//   bram_wr         block-RAM write strobe
//   bram_addr       byte offset within the current region
//   bram_data       block-RAM write data
//   bram_cs         one-hot region select, valid with bram_wr
//   sdram_req       SDRAM write request (level)
//   sdram_addr      SDRAM byte address
//   sdram_data      SDRAM write data
//   sdram_ack       one-cycle SDRAM acknowledge
//   load_done       sticky; all regions loaded
//   load_err        sticky; early end of download, offset overflow or checksum fault
module rom_region_loader #(
  parameter int NUM_REGIONS = 8,
  parameter int SDRAM_AW    = 25
) (
  input  logic                   clk_bram,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic                   bram_wr,
  output logic [19:0]            bram_addr,
  output logic [7:0]             bram_data,
  output logic [NUM_REGIONS-1:0] bram_cs,
  output logic                   sdram_req,
  output logic [SDRAM_AW-1:0]    sdram_addr,
  output logic [7:0]             sdram_data,
  input  logic                   sdram_ack,
  output logic                   load_done,
  output logic                   load_err
);

`ifdef REGION_CHECKSUM_EN
  localparam int ENTRY_BYTES = 5;
`else
  localparam int ENTRY_BYTES = 4;
`endif
  // Wide enough to hold NUM_REGIONS itself, which is the "all regions done" value.
  localparam int IW = $clog2(NUM_REGIONS + 1);

  localparam logic [7:0] T_BRAM  = 8'd1;
  localparam logic [7:0] T_SDRAM = 8'd2;
  localparam logic [7:0] T_SKIP  = 8'd3;

  typedef enum logic [2:0] {
    IDLE, HEADER, SELECT, PAYLOAD, SDRAM_WAIT, DONE
  } state_t;

  state_t                state_reg, state_next;
  logic                  dl_prev_reg;
  logic [IW-1:0]         index_reg, index_next;
  logic [2:0]            hbyte_reg, hbyte_next;
  logic [23:0]           remaining_reg, remaining_next;
  // Bit 20 flags that the 20-bit block-RAM offset space is used up.
  logic [20:0]           offset_reg, offset_next;
  logic                  bram_wr_reg, bram_wr_next;
  logic [19:0]           bram_addr_reg, bram_addr_next;
  logic [7:0]            bram_data_reg, bram_data_next;
  logic [NUM_REGIONS-1:0] bram_cs_reg, bram_cs_next;
  logic                  sdram_req_reg, sdram_req_next;
  logic [SDRAM_AW-1:0]   sdram_addr_reg, sdram_addr_next;
  logic [7:0]            sdram_data_reg, sdram_data_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
`ifdef REGION_CHECKSUM_EN
  logic [7:0]            sum_reg, sum_next;
  logic [7:0]            sum_new;
  logic [7:0]            cur_sum;
  logic [7:0]            sum_arr [NUM_REGIONS];
`endif

  // Header entry table, one register set per region.
  logic [7:0]  type_arr [NUM_REGIONS];
  logic [23:0] len_arr  [NUM_REGIONS];
  logic        hdr_we;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_entry
      logic [7:0]  etype;
      logic [23:0] elen;
      logic        sel;
      assign sel = hdr_we && (index_reg == IW'(gi));
      always_ff @(posedge clk_bram or posedge reset) begin
        if (reset) begin
          etype <= '0;
          elen  <= '0;
        end else if (sel) begin
          case (hbyte_reg)
            3'd0:    etype       <= ioctl_dout;
            3'd1:    elen[23:16] <= ioctl_dout;
            3'd2:    elen[15:8]  <= ioctl_dout;
            3'd3:    elen[7:0]   <= ioctl_dout;
            default: ;
          endcase
        end
      end
      assign type_arr[gi] = etype;
      assign len_arr[gi]  = elen;
`ifdef REGION_CHECKSUM_EN
      logic [7:0] esum;
      always_ff @(posedge clk_bram or posedge reset) begin
        if (reset) esum <= '0;
        else if (sel && hbyte_reg == 3'd4) esum <= ioctl_dout;
      end
      assign sum_arr[gi] = esum;
`endif
    end
  endgenerate

  // Entry selected by the current region index (all zero once index is past the table).
  logic [7:0]  cur_type;
  logic [23:0] cur_len;
  always_comb begin
    cur_type = '0;
    cur_len  = '0;
`ifdef REGION_CHECKSUM_EN
    cur_sum  = '0;
`endif
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (index_reg == IW'(i)) begin
        cur_type = type_arr[i];
        cur_len  = len_arr[i];
`ifdef REGION_CHECKSUM_EN
        cur_sum  = sum_arr[i];
`endif
      end
    end
  end

  logic dl_rise;
  logic busy;
  logic last_byte;
  logic cur_used;
  assign dl_rise  = ioctl_download & ~dl_prev_reg;
  assign busy     = state_reg inside {HEADER, SELECT, PAYLOAD, SDRAM_WAIT};
  assign cur_used = (cur_type == T_BRAM) || (cur_type == T_SDRAM) || (cur_type == T_SKIP);

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    hbyte_next      = hbyte_reg;
    remaining_next  = remaining_reg;
    offset_next     = offset_reg;
    bram_wr_next    = 1'b0;
    bram_addr_next  = bram_addr_reg;
    bram_data_next  = bram_data_reg;
    bram_cs_next    = '0;
    sdram_req_next  = sdram_req_reg;
    sdram_addr_next = sdram_addr_reg;
    sdram_data_next = sdram_data_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    hdr_we          = 1'b0;
    last_byte       = 1'b0;
`ifdef REGION_CHECKSUM_EN
    sum_next        = sum_reg;
    sum_new         = sum_reg + ioctl_dout;
`endif

    if (busy && !ioctl_download) begin
      // Download ended early: flag it and abandon any outstanding SDRAM write.
      err_next       = 1'b1;
      sdram_req_next = 1'b0;
      state_next     = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dl_rise) begin
            done_next       = 1'b0;
            err_next        = 1'b0;
            index_next      = '0;
            hbyte_next      = '0;
            sdram_addr_next = '0;
            state_next      = HEADER;
          end
        end

        HEADER: begin
          if (ioctl_wr) begin
            hdr_we = 1'b1;
            if (hbyte_reg == 3'(ENTRY_BYTES - 1)) begin
              hbyte_next = '0;
              if (index_reg == IW'(NUM_REGIONS - 1)) begin
                index_next = '0;
                state_next = SELECT;
              end else begin
                index_next = index_reg + IW'(1);
              end
            end else begin
              hbyte_next = hbyte_reg + 3'd1;
            end
          end
        end

        SELECT: begin
          if (index_reg == IW'(NUM_REGIONS)) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else if (!cur_used || cur_len == 24'd0) begin
            index_next = index_reg + IW'(1);
          end else begin
            remaining_next = cur_len;
            offset_next    = '0;
`ifdef REGION_CHECKSUM_EN
            sum_next       = '0;
`endif
            state_next     = PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (ioctl_wr) begin
            last_byte      = (remaining_reg == 24'd1);
            remaining_next = remaining_reg - 24'd1;
            if (!offset_reg[20]) offset_next = offset_reg + 21'd1;
            case (cur_type)
              T_BRAM: begin
                if (offset_reg[20]) begin
                  err_next = 1'b1;
                end else begin
                  bram_wr_next   = 1'b1;
                  bram_addr_next = offset_reg[19:0];
                  bram_data_next = ioctl_dout;
                  bram_cs_next   = NUM_REGIONS'(1) << index_reg;
                end
              end
              T_SDRAM: begin
                sdram_data_next = ioctl_dout;
                sdram_req_next  = 1'b1;
                state_next      = SDRAM_WAIT;
              end
              default: ;
            endcase
`ifdef REGION_CHECKSUM_EN
            sum_next = sum_new;
            if (last_byte && sum_new != cur_sum) err_next = 1'b1;
`endif
            // SDRAM regions leave from SDRAM_WAIT once the last byte is acknowledged.
            if (last_byte && cur_type != T_SDRAM) begin
              index_next = index_reg + IW'(1);
              state_next = SELECT;
            end
          end
        end

        SDRAM_WAIT: begin
          if (sdram_ack) begin
            sdram_req_next  = 1'b0;
            sdram_addr_next = sdram_addr_reg + SDRAM_AW'(1);
            if (remaining_reg == 24'd0) begin
              index_next = index_reg + IW'(1);
              state_next = SELECT;
            end else begin
              state_next = PAYLOAD;
            end
          end
        end

        DONE: begin
          if (!ioctl_download) state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_bram or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      dl_prev_reg    <= 1'b0;
      index_reg      <= '0;
      hbyte_reg      <= '0;
      remaining_reg  <= '0;
      offset_reg     <= '0;
      bram_wr_reg    <= 1'b0;
      bram_addr_reg  <= '0;
      bram_data_reg  <= '0;
      bram_cs_reg    <= '0;
      sdram_req_reg  <= 1'b0;
      sdram_addr_reg <= '0;
      sdram_data_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef REGION_CHECKSUM_EN
      sum_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      dl_prev_reg    <= ioctl_download;
      index_reg      <= index_next;
      hbyte_reg      <= hbyte_next;
      remaining_reg  <= remaining_next;
      offset_reg     <= offset_next;
      bram_wr_reg    <= bram_wr_next;
      bram_addr_reg  <= bram_addr_next;
      bram_data_reg  <= bram_data_next;
      bram_cs_reg    <= bram_cs_next;
      sdram_req_reg  <= sdram_req_next;
      sdram_addr_reg <= sdram_addr_next;
      sdram_data_reg <= sdram_data_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
`ifdef REGION_CHECKSUM_EN
      sum_reg        <= sum_next;
`endif
    end
  end

  // The source is stalled while a region is being selected or an SDRAM write is pending.
  assign ioctl_wait = (state_reg == SELECT) | sdram_req_reg;
  assign bram_wr    = bram_wr_reg;
  assign bram_addr  = bram_addr_reg;
  assign bram_data  = bram_data_reg;
  assign bram_cs    = bram_cs_reg;
  assign sdram_req  = sdram_req_reg;
  assign sdram_addr = sdram_addr_reg;
  assign sdram_data = sdram_data_reg;
  assign load_done  = done_reg;
  assign load_err   = err_reg;

endmodule

// File: tb/tb_rom_region_loader.sv
// Directed testbench for rom_region_loader. It covers block-RAM routing, SDRAM
// handshaking with a delayed ack, mixed region packing, unused/zero-length/skip
// entries, async reset, early download termination and, when
// REGION_CHECKSUM_EN is defined, the region checksum.
module tb_rom_region_loader;
  localparam int NR = 8;
  localparam int AW = 25;

  logic          clk_bram = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic          ioctl_wait;
  logic          bram_wr;
  logic [19:0]   bram_addr;
  logic [7:0]    bram_data;
  logic [NR-1:0] bram_cs;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_data;
  logic          sdram_ack = 1'b0;
  logic          load_done;
  logic          load_err;

  rom_region_loader #(.NUM_REGIONS(NR), .SDRAM_AW(AW)) dut (
    .clk_bram(clk_bram), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_data(bram_data), .bram_cs(bram_cs),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_ack(sdram_ack), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk_bram = ~clk_bram;

  int tests_run = 0;
  int tests_failed = 0;

  int ack_delay = 2;
  bit ack_enable = 1'b1;
  bit req_seen = 1'b0;
  bit ack_done = 1'b0;
  int ack_cnt = 0;
  int wait_viol = 0;
  int stable_viol = 0;

  logic [NR-1:0] bw_cs_q[$];
  logic [19:0]   bw_addr_q[$];
  logic [7:0]    bw_data_q[$];
  logic [AW-1:0] sd_addr_q[$];
  logic [7:0]    sd_data_q[$];

  // Block-RAM write log, plus a flag for any pending request the source was not told to stall for.
  always @(negedge clk_bram) begin
    if (bram_wr) begin
      bw_cs_q.push_back(bram_cs);
      bw_addr_q.push_back(bram_addr);
      bw_data_q.push_back(bram_data);
    end
    if (sdram_req && !ioctl_wait) wait_viol++;
  end

  // SDRAM model: log each new request, check it stays stable, ack after ack_delay cycles.
  always @(negedge clk_bram) begin
    sdram_ack = 1'b0;
    if (sdram_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        ack_cnt = 0;
        sd_addr_q.push_back(sdram_addr);
        sd_data_q.push_back(sdram_data);
      end else begin
        ack_cnt++;
        if (sd_addr_q.size() > 0)
          if (sdram_addr !== sd_addr_q[$] || sdram_data !== sd_data_q[$]) stable_viol++;
      end
      if (ack_enable && !ack_done && ack_cnt >= ack_delay) begin
        sdram_ack = 1'b1;
        ack_done = 1'b1;
      end
    end else begin
      req_seen = 1'b0;
      ack_done = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_bram);
  endtask

  task automatic clear_logs();
    bw_cs_q.delete(); bw_addr_q.delete(); bw_data_q.delete();
    sd_addr_q.delete(); sd_data_q.delete();
    wait_viol = 0; stable_viol = 0;
  endtask

  task automatic start_dl();
    @(negedge clk_bram); ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    @(negedge clk_bram); ioctl_download = 1'b0;
    tick(2);
  endtask

  // Honour ioctl_wait, then strobe one byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_bram);
    while (ioctl_wait && n < 200) begin @(negedge clk_bram); n++; end
    if (ioctl_wait) begin
      tests_run++; tests_failed++;
      $display("FAIL send_byte_wait: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, n);
    end
    ioctl_dout = b; ioctl_wr = 1'b1;
    @(negedge clk_bram); ioctl_wr = 1'b0;
  endtask

  task automatic send_entry(input logic [7:0] t, input logic [23:0] len, input logic [7:0] s);
    send_byte(t); send_byte(len[23:16]); send_byte(len[15:8]); send_byte(len[7:0]);
`ifdef REGION_CHECKSUM_EN
    send_byte(s);
`else
    if (s === 8'hxx) tick(0);
`endif
  endtask

  task automatic pad_entries(input int used);
    for (int i = used; i < NR; i++) send_entry(8'd0, 24'd0, 8'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 300) begin @(negedge clk_bram); n++; end
  endtask

  task automatic test_reset();
    tick(3);
    tests_run++;
    if ({ioctl_wait, bram_wr, bram_addr, bram_data, bram_cs, sdram_req, sdram_addr, sdram_data, load_done, load_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: wait=%b wr=%b addr=%h data=%h cs=%h req=%b saddr=%h sdata=%h done=%b err=%b, required all 0",
               ioctl_wait, bram_wr, bram_addr, bram_data, bram_cs, sdram_req, sdram_addr, sdram_data, load_done, load_err);
    end
    @(negedge clk_bram); reset = 1'b0;
    // Bytes without a download must be ignored.
    ioctl_dout = 8'h5A; ioctl_wr = 1'b1; @(negedge clk_bram); ioctl_wr = 1'b0;
    tick(3);
    tests_run++;
    if (bw_cs_q.size() != 0 || sdram_req !== 1'b0 || ioctl_wait !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignore: writes=%0d req=%b wait=%b, required 0 0 0", bw_cs_q.size(), sdram_req, ioctl_wait);
    end
  endtask

  task automatic test_bram();
    logic [7:0]  pay  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0]  ecs  [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
    logic [19:0] eadr [6] = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd0, 20'd1};
    clear_logs(); start_dl();
    send_entry(8'd1, 24'd4, 8'hAA); send_entry(8'd1, 24'd2, 8'hBB); pad_entries(2);
    for (int i = 0; i < 6; i++) send_byte(pay[i]);
    wait_done(); tick(2);
    tests_run++;
    if (bw_cs_q.size() != 6) begin
      tests_failed++; $display("FAIL bram_count: got %0d writes, required 6", bw_cs_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= bw_cs_q.size()) begin
        tests_failed++; $display("FAIL bram_write%0d: missing, required cs=%h addr=%h data=%h", i, ecs[i], eadr[i], pay[i]);
      end else if ({bw_cs_q[i], bw_addr_q[i], bw_data_q[i]} !== {ecs[i], eadr[i], pay[i]}) begin
        tests_failed++;
        $display("FAIL bram_write%0d: got cs=%h addr=%h data=%h, required cs=%h addr=%h data=%h",
                 i, bw_cs_q[i], bw_addr_q[i], bw_data_q[i], ecs[i], eadr[i], pay[i]);
      end
    end
    tests_run++;
    if ({load_done, load_err} !== 2'b10 || sd_addr_q.size() != 0) begin
      tests_failed++; $display("FAIL bram_flags: done=%b err=%b sdram_reqs=%0d, required 1 0 0", load_done, load_err, sd_addr_q.size());
    end
    end_dl();
  endtask

  task automatic test_sdram();
    logic [7:0] pay [3] = '{8'hA0, 8'hA1, 8'hA2};
    clear_logs(); ack_delay = 5; start_dl();
    send_entry(8'd2, 24'd3, 8'hE3); pad_entries(1);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    wait_done(); tick(2);
    tests_run++;
    if (sd_addr_q.size() != 3) begin
      tests_failed++; $display("FAIL sdram_count: got %0d requests, required 3", sd_addr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= sd_addr_q.size()) begin
        tests_failed++; $display("FAIL sdram_req%0d: missing, required addr=%0d data=%h", i, i, pay[i]);
      end else if ({sd_addr_q[i], sd_data_q[i]} !== {AW'(i), pay[i]}) begin
        tests_failed++;
        $display("FAIL sdram_req%0d: got addr=%0d data=%h, required addr=%0d data=%h", i, sd_addr_q[i], sd_data_q[i], i, pay[i]);
      end
    end
    tests_run++;
    if (wait_viol != 0 || stable_viol != 0) begin
      tests_failed++; $display("FAIL sdram_handshake: wait_low_cycles=%0d unstable_cycles=%0d, required 0 0", wait_viol, stable_viol);
    end
    tests_run++;
    if ({load_done, load_err} !== 2'b10 || bw_cs_q.size() != 0) begin
      tests_failed++; $display("FAIL sdram_flags: done=%b err=%b bram_writes=%0d, required 1 0 0", load_done, load_err, bw_cs_q.size());
    end
    end_dl(); ack_delay = 2;
  endtask

  task automatic test_mixed();
    logic [7:0] spay [4] = '{8'hB0, 8'hB1, 8'hD0, 8'hD1};
    clear_logs(); start_dl();
    send_entry(8'd2, 24'd2, 8'h61); send_entry(8'd1, 24'd1, 8'hC0); send_entry(8'd2, 24'd2, 8'hA1);
    pad_entries(3);
    send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hC0); send_byte(8'hD0); send_byte(8'hD1);
    wait_done(); tick(2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= sd_addr_q.size()) begin
        tests_failed++; $display("FAIL mixed_sdram%0d: missing, required addr=%0d data=%h", i, i, spay[i]);
      end else if ({sd_addr_q[i], sd_data_q[i]} !== {AW'(i), spay[i]}) begin
        tests_failed++;
        $display("FAIL mixed_sdram%0d: got addr=%0d data=%h, required addr=%0d data=%h", i, sd_addr_q[i], sd_data_q[i], i, spay[i]);
      end
    end
    tests_run++;
    if (bw_cs_q.size() != 1 || {bw_cs_q[0], bw_addr_q[0], bw_data_q[0]} !== {8'h02, 20'd0, 8'hC0}) begin
      tests_failed++;
      $display("FAIL mixed_bram: got %0d writes (first cs=%h addr=%h data=%h), required 1 write cs=02 addr=0 data=c0",
               bw_cs_q.size(), bw_cs_q.size() > 0 ? bw_cs_q[0] : 8'h00,
               bw_addr_q.size() > 0 ? bw_addr_q[0] : 20'h0, bw_data_q.size() > 0 ? bw_data_q[0] : 8'h00);
    end
    tests_run++;
    if ({load_done, load_err} !== 2'b10 || sd_addr_q.size() != 4) begin
      tests_failed++; $display("FAIL mixed_flags: done=%b err=%b reqs=%0d, required 1 0 4", load_done, load_err, sd_addr_q.size());
    end
    end_dl();
  endtask

  task automatic test_skip();
    clear_logs(); start_dl();
    send_entry(8'd0, 24'd0, 8'h00); send_entry(8'd1, 24'd0, 8'h00);
    send_entry(8'd3, 24'd2, 8'hFE); send_entry(8'd1, 24'd1, 8'h7E);
    pad_entries(4);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7E);
    wait_done(); tick(2);
    tests_run++;
    if (bw_cs_q.size() != 1 || {bw_cs_q[0], bw_addr_q[0], bw_data_q[0]} !== {8'h08, 20'd0, 8'h7E}) begin
      tests_failed++;
      $display("FAIL skip_bram: got %0d writes (first cs=%h addr=%h data=%h), required 1 write cs=08 addr=0 data=7e",
               bw_cs_q.size(), bw_cs_q.size() > 0 ? bw_cs_q[0] : 8'h00,
               bw_addr_q.size() > 0 ? bw_addr_q[0] : 20'h0, bw_data_q.size() > 0 ? bw_data_q[0] : 8'h00);
    end
    tests_run++;
    if ({load_done, load_err} !== 2'b10 || sd_addr_q.size() != 0) begin
      tests_failed++; $display("FAIL skip_flags: done=%b err=%b reqs=%0d, required 1 0 0", load_done, load_err, sd_addr_q.size());
    end
    end_dl();
  endtask

  // Runs after test_skip, whose load_done is still set once the download has ended.
  task automatic test_reset_mid();
    tests_run++;
    if (load_done !== 1'b1) begin
      tests_failed++; $display("FAIL done_sticky: load_done=%b after download end, required 1", load_done);
    end
    @(negedge clk_bram); #2 reset = 1'b1; #1;
    tests_run++;
    if (load_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_clears_done: load_done=%b, required 0", load_done);
    end
    @(negedge clk_bram); reset = 1'b0;
    clear_logs(); start_dl();
    send_entry(8'd2, 24'd1, 8'h00); pad_entries(1);
    ack_enable = 1'b0;
    send_byte(8'h90); tick(2);
    tests_run++;
    if (sdram_req !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid_pending: sdram_req=%b, required 1", sdram_req);
    end
    #2 reset = 1'b1; #1;
    tests_run++;
    if ({sdram_req, ioctl_wait, load_err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_mid_drop: req=%b wait=%b err=%b, required 0 0 0", sdram_req, ioctl_wait, load_err);
    end
    ioctl_download = 1'b0;
    @(negedge clk_bram); reset = 1'b0;
    ack_enable = 1'b1;
    tick(2);
  endtask

  task automatic test_abort();
    int n;
    clear_logs(); start_dl();
    send_entry(8'd2, 24'd4, 8'h00); pad_entries(1);
    send_byte(8'hE0);
    n = 0;
    while (ioctl_wait && n < 50) begin @(negedge clk_bram); n++; end
    ack_enable = 1'b0;
    send_byte(8'hE1); tick(2);
    tests_run++;
    if (sdram_req !== 1'b1 || sd_addr_q.size() != 2) begin
      tests_failed++; $display("FAIL abort_pending: req=%b reqs=%0d, required 1 2", sdram_req, sd_addr_q.size());
    end
    ioctl_download = 1'b0;
    @(negedge clk_bram);
    tests_run++;
    if ({sdram_req, ioctl_wait, load_done, load_err} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL abort_flags: req=%b wait=%b done=%b err=%b, required 0 0 0 1", sdram_req, ioctl_wait, load_done, load_err);
    end
    tick(3); ack_enable = 1'b1;
    // A fresh download must start from IDLE and clear the error.
    clear_logs(); start_dl();
    tests_run++;
    if (load_err !== 1'b0) begin
      tests_failed++; $display("FAIL abort_restart_clear: load_err=%b, required 0", load_err);
    end
    send_entry(8'd1, 24'd1, 8'h3C); pad_entries(1);
    send_byte(8'h3C);
    wait_done(); tick(2);
    tests_run++;
    if ({load_done, load_err} !== 2'b10 || bw_cs_q.size() != 1 || bw_data_q.size() != 1 || bw_data_q[0] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL abort_restart_load: done=%b err=%b writes=%0d, required 1 0 1 write of 3c", load_done, load_err, bw_cs_q.size());
    end
    end_dl();
  endtask

`ifdef REGION_CHECKSUM_EN
  task automatic test_checksum();
    clear_logs(); start_dl();
    send_entry(8'd1, 24'd3, 8'h07); send_entry(8'd1, 24'd3, 8'h08); send_entry(8'd1, 24'd1, 8'h5A);
    pad_entries(3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); tick(3);
    tests_run++;
    if (load_err !== 1'b0) begin
      tests_failed++; $display("FAIL checksum_match: load_err=%b, required 0", load_err);
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); tick(3);
    tests_run++;
    if (load_err !== 1'b1) begin
      tests_failed++; $display("FAIL checksum_mismatch: load_err=%b, required 1", load_err);
    end
    send_byte(8'h5A);
    wait_done(); tick(2);
    tests_run++;
    if (load_done !== 1'b1 || bw_cs_q.size() != 7 || {bw_cs_q[$], bw_addr_q[$], bw_data_q[$]} !== {8'h04, 20'd0, 8'h5A}) begin
      tests_failed++;
      $display("FAIL checksum_continue: done=%b writes=%0d, required 1 and 7 writes ending cs=04 addr=0 data=5a", load_done, bw_cs_q.size());
    end
    end_dl();
  endtask
`endif

  initial begin
    test_reset();
    test_bram();
    test_sdram();
    test_mixed();
    test_skip();
    test_reset_mid();
    test_abort();
`ifdef REGION_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1);
  end

endmodule
